// File: rtl/mac_seq_unit.sv
// Sequential 8x8 unsigned shift-add multiply-accumulate unit with a sticky overflow flag.
// It also drives the load/shift/hold select code for the downstream 3-to-1 operand mux.
module mac_seq_unit #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clear,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] acc,
   output logic             ovf,
   output logic [1:0]       op_sel,
   output logic [2:0]       dbg_state
);

   localparam int SUM_W = ACC_W + 1;

   localparam logic [1:0] SEL_LOAD  = 2'b00;
   localparam logic [1:0] SEL_SHIFT = 2'b01;
   localparam logic [1:0] SEL_HOLD  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MULT  = 3'd2,
      S_ACCUM = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   mpr_q;
   logic [2:0]         cnt_q;
   logic [ACC_W-1:0]   acc_q;
   logic               ovf_q;
   logic               busy_q;
   logic               done_q;
   logic [1:0]         op_sel_q;
   logic [SUM_W-1:0]   acc_sum_d;

   // Handshake: start and clear are level requests sampled only in IDLE; busy high means
   // the unit is not ready and both are dropped, done pulses once when acc holds the new sum.
   always_comb begin
      acc_sum_d = {1'b0, acc_q} + SUM_W'(prod_q);
   end

   // Outputs are registered from the state being entered, so they behave as Moore outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         prod_q   <= '0;
         mpr_q    <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         op_sel_q <= SEL_HOLD;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clear) begin
                  acc_q <= '0;
                  ovf_q <= 1'b0;
               end else if (start) begin
                  state_q  <= S_LOAD;
                  busy_q   <= 1'b1;
                  op_sel_q <= SEL_LOAD;
               end
            end
            S_LOAD: begin
               mcand_q  <= {{WIDTH{1'b0}}, a};
               mpr_q    <= b;
               prod_q   <= '0;
               cnt_q    <= '0;
               state_q  <= S_MULT;
               op_sel_q <= SEL_SHIFT;
            end
            S_MULT: begin
               // Always 8 iterations, even for zero operands, so latency is fixed.
               if (mpr_q[0]) begin
                  prod_q <= prod_q + mcand_q;
               end
               mcand_q <= mcand_q << 1;
               mpr_q   <= mpr_q >> 1;
               cnt_q   <= cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_q  <= S_ACCUM;
                  op_sel_q <= SEL_HOLD;
               end
            end
            S_ACCUM: begin
               acc_q   <= acc_sum_d[ACC_W-1:0];
               ovf_q   <= ovf_q | acc_sum_d[ACC_W];
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               op_sel_q <= SEL_HOLD;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign acc       = acc_q;
   assign ovf       = ovf_q;
   assign op_sel    = op_sel_q;
   assign dbg_state = state_q;

endmodule
